// File: rtl/ahb_read.sv
// AHB-Lite slave read-data path: returns payload_0/payload_1/data_size after WAIT_STATES
// wait cycles (OKAY) or a two-cycle ERROR for select 3; stalls the bus via hready_out only.
module ahb_read #(
  parameter int WAIT_STATES = 1
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic       hsel_x,
  input  logic       hready,
  input  logic       hwrite,
  input  logic [1:0] htrans,
  input  logic [1:0] read_select,
  input  logic [7:0] payload_0,
  input  logic [7:0] payload_1,
  input  logic [4:0] data_size,
  output logic [7:0] hrdata,
  output logic       hready_out,
  output logic       hresp
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  state_t     state;
  logic [2:0] wait_cnt;
  logic [1:0] sel_q;
  logic       accept;
  logic [7:0] new_dat;
  logic [7:0] cap_dat;
  logic       unused_htrans;

  function automatic logic [7:0] reg_mux(input logic [1:0] s, input logic [7:0] p0,
                                         input logic [7:0] p1, input logic [4:0] ds);
    case (s)
      2'd0:    return p0;
      2'd1:    return p1;
      default: return {3'b000, ds};
    endcase
  endfunction

  // only NONSEQ/SEQ matter, so htrans[0] is deliberately ignored
  assign unused_htrans = htrans[0];
  assign accept  = hsel_x && hready && !hwrite && htrans[1];
  // zero-wait reads sample the registers on the accept edge; waited reads on the RESP entry edge
  assign new_dat = reg_mux(read_select, payload_0, payload_1, data_size);
  assign cap_dat = reg_mux(sel_q, payload_0, payload_1, data_size);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state      <= ST_IDLE;
      hrdata     <= 8'h00;
      hready_out <= 1'b1;
      hresp      <= 1'b0;
      wait_cnt   <= 3'd0;
      sel_q      <= 2'd0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP, ST_ERR2: begin
          if (accept) begin
            sel_q <= read_select;
            if (read_select == 2'd3) begin
              state      <= ST_ERR1;
              hready_out <= 1'b0;
              hresp      <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state      <= ST_RESP;
              hready_out <= 1'b1;
              hresp      <= 1'b0;
              hrdata     <= new_dat;
            end else begin
              state      <= ST_WAIT;
              wait_cnt   <= WAIT_LOAD;
              hready_out <= 1'b0;
              hresp      <= 1'b0;
            end
          end else begin
            state      <= ST_IDLE;
            hready_out <= 1'b1;
            hresp      <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state      <= ST_RESP;
            hready_out <= 1'b1;
            hresp      <= 1'b0;
            hrdata     <= cap_dat;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          state      <= ST_ERR2;
          hready_out <= 1'b1;
          hresp      <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          hready_out <= 1'b1;
          hresp      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_read.sv
// Scoreboard bench for ahb_read with three instances (WAIT_STATES = 0, 1, 3) on a shared bus.
module tb_ahb_read;

  logic       hclk = 1'b0;
  logic       hreset;
  logic       hsel_x;
  logic       hready;
  logic       hwrite;
  logic [1:0] htrans;
  logic [1:0] read_select;
  logic [7:0] payload_0;
  logic [7:0] payload_1;
  logic [4:0] data_size;
  logic [7:0] rd  [3];
  logic       rdy [3];
  logic       rsp [3];

  localparam int D0 = 0;  // WAIT_STATES = 0
  localparam int D1 = 1;  // WAIT_STATES = 1
  localparam int D3 = 2;  // WAIT_STATES = 3

  always #5 hclk = ~hclk;

  ahb_read #(.WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .hsel_x(hsel_x), .hready(hready), .hwrite(hwrite),
    .htrans(htrans), .read_select(read_select), .payload_0(payload_0), .payload_1(payload_1),
    .data_size(data_size), .hrdata(rd[0]), .hready_out(rdy[0]), .hresp(rsp[0]));

  ahb_read #(.WAIT_STATES(1)) u_ws1 (
    .hclk(hclk), .hreset(hreset), .hsel_x(hsel_x), .hready(hready), .hwrite(hwrite),
    .htrans(htrans), .read_select(read_select), .payload_0(payload_0), .payload_1(payload_1),
    .data_size(data_size), .hrdata(rd[1]), .hready_out(rdy[1]), .hresp(rsp[1]));

  ahb_read #(.WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .hsel_x(hsel_x), .hready(hready), .hwrite(hwrite),
    .htrans(htrans), .read_select(read_select), .payload_0(payload_0), .payload_1(payload_1),
    .data_size(data_size), .hrdata(rd[2]), .hready_out(rdy[2]), .hresp(rsp[2]));

  typedef struct {
    int         cyc;
    int         dut;
    logic       rdy;
    logic       rsp;
    logic [7:0] dat;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  // monitor: compares every expectation due in the current cycle, away from the clock edge
  always @(negedge hclk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc != cyc || rdy[sb[i].dut] !== sb[i].rdy || rsp[sb[i].dut] !== sb[i].rsp ||
            rd[sb[i].dut] !== sb[i].dat) begin
          errors++;
          $display("FAIL %s dut%0d cyc%0d: got rdy=%b resp=%b dat=%02h, want rdy=%b resp=%b dat=%02h (due cyc%0d)",
                   sb[i].nm, sb[i].dut, cyc, rdy[sb[i].dut], rsp[sb[i].dut], rd[sb[i].dut],
                   sb[i].rdy, sb[i].rsp, sb[i].dat, sb[i].cyc);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push_exp(input int c, input int d, input logic r, input logic e,
                          input logic [7:0] v, input string nm);
    exp_t x;
    x.cyc = c; x.dut = d; x.rdy = r; x.rsp = e; x.dat = v; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic bus_idle();
    hsel_x = 1'b0; hready = 1'b1; hwrite = 1'b0; htrans = 2'b00; read_select = 2'd0;
  endtask

  task automatic rd_addr(input logic [1:0] s);
    hsel_x = 1'b1; hready = 1'b1; hwrite = 1'b0; htrans = 2'b10; read_select = s;
  endtask

  initial begin
    int n;
    hreset = 1'b0;
    bus_idle();
    payload_0 = 8'h00; payload_1 = 8'h00; data_size = 5'h00;

    // asynchronous reset asserted mid-cycle, before any clock edge
    #2 hreset = 1'b1;
    for (int d = 0; d < 3; d++) push_exp(1, d, 1'b1, 1'b0, 8'h00, "reset_async");
    step();
    step();
    hreset = 1'b0;
    for (int d = 0; d < 3; d++) push_exp(cyc, d, 1'b1, 1'b0, 8'h00, "post_reset_idle");
    step();

    // single read of payload_0 seen by all three wait-state settings
    payload_0 = 8'hA5;
    n = cyc;
    rd_addr(2'd0);
    push_exp(n + 1, D1, 1'b0, 1'b0, 8'h00, "ws1_wait");
    push_exp(n + 2, D1, 1'b1, 1'b0, 8'hA5, "ws1_data");
    push_exp(n + 3, D1, 1'b1, 1'b0, 8'hA5, "ws1_idle_hold");
    push_exp(n + 1, D0, 1'b1, 1'b0, 8'hA5, "ws0_data");
    push_exp(n + 1, D3, 1'b0, 1'b0, 8'h00, "ws3_wait_first");
    push_exp(n + 3, D3, 1'b0, 1'b0, 8'h00, "ws3_wait_last");
    push_exp(n + 4, D3, 1'b1, 1'b0, 8'hA5, "ws3_data");
    step();
    bus_idle();
    step(5);

    // back-to-back zero-wait reads of payload_1 then data_size
    payload_1 = 8'h3C;
    data_size = 5'h13;
    n = cyc;
    rd_addr(2'd1);
    push_exp(n + 1, D0, 1'b1, 1'b0, 8'h3C, "b2b_first");
    push_exp(n + 2, D0, 1'b1, 1'b0, 8'h13, "b2b_second");
    push_exp(n + 3, D0, 1'b1, 1'b0, 8'h13, "b2b_idle_hold");
    push_exp(n + 2, D1, 1'b1, 1'b0, 8'h3C, "ws1_ignores_in_wait");
    step();
    rd_addr(2'd2);
    step();
    bus_idle();
    step(5);

    // invalid select: two-cycle ERROR independent of WAIT_STATES
    n = cyc;
    rd_addr(2'd3);
    push_exp(n + 1, D1, 1'b0, 1'b1, 8'h3C, "err1_ws1");
    push_exp(n + 2, D1, 1'b1, 1'b1, 8'h3C, "err2_ws1");
    push_exp(n + 3, D1, 1'b1, 1'b0, 8'h3C, "err_idle_ws1");
    push_exp(n + 1, D3, 1'b0, 1'b1, 8'h3C, "err1_ws3");
    push_exp(n + 2, D3, 1'b1, 1'b1, 8'h3C, "err2_ws3");
    push_exp(n + 1, D0, 1'b0, 1'b1, 8'h13, "err1_ws0");
    step();
    bus_idle();
    step(5);

    // filtered address phases: none may start a transfer
    payload_0 = 8'h77;
    for (int k = 0; k < 5; k++) begin
      rd_addr(2'd0);
      case (k)
        0:       hwrite = 1'b1;
        1:       htrans = 2'b00;
        2:       htrans = 2'b01;
        3:       hsel_x = 1'b0;
        default: hready = 1'b0;
      endcase
      push_exp(cyc + 1, D0, 1'b1, 1'b0, 8'h13, $sformatf("filter%0d_ws0", k));
      push_exp(cyc + 1, D1, 1'b1, 1'b0, 8'h3C, $sformatf("filter%0d_ws1", k));
      step();
    end
    bus_idle();
    step(3);

    // reset during the second wait cycle, then a clean read
    payload_0 = 8'h5A;
    n = cyc;
    rd_addr(2'd0);
    push_exp(n + 1, D3, 1'b0, 1'b0, 8'h3C, "ws3_wait_before_reset");
    step();
    bus_idle();
    step();
    hreset = 1'b1;
    push_exp(n + 2, D3, 1'b1, 1'b0, 8'h00, "reset_mid_wait");
    push_exp(n + 2, D1, 1'b1, 1'b0, 8'h00, "reset_mid_resp_ws1");
    step();
    hreset = 1'b0;
    push_exp(n + 3, D3, 1'b1, 1'b0, 8'h00, "after_reset_idle");
    push_exp(n + 4, D3, 1'b1, 1'b0, 8'h00, "no_late_resp");
    step(2);
    payload_1 = 8'hC3;
    n = cyc;
    rd_addr(2'd1);
    push_exp(n + 1, D3, 1'b0, 1'b0, 8'h00, "rerun_wait_first");
    push_exp(n + 3, D3, 1'b0, 1'b0, 8'h00, "rerun_wait_last");
    push_exp(n + 4, D3, 1'b1, 1'b0, 8'hC3, "rerun_data");
    push_exp(n + 5, D3, 1'b1, 1'b0, 8'hC3, "rerun_idle_hold");
    step();
    bus_idle();
    step(7);

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", sb.size());
      errors += sb.size();
      checks += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_read.md
Name: ahb_read

Overview:
- AHB-Lite slave read-data path; companion to the slave write path that fills payload_0, payload_1 and data_size.
- Accepts read address phases and returns the selected register on hrdata after a configurable number of wait states.
- Signals ERROR with the two-cycle AHB error response for an invalid select.
- Sits beside the write path on the same hsel_x decode; registered outputs only.

Parameters:
WAIT_STATES, 1, data-phase wait cycles inserted before an OKAY read completes (legal 0..7, 3-bit counter)

Ports:
hclk  input  1  bus clock, all logic on rising edge
hreset  input  1  asynchronous, active-high reset
hsel_x  input  1  slave select from address decoder
hready  input  1  bus-level HREADY; an address phase is sampled only when high
hwrite  input  1  transfer direction; 0 = read
htrans  input  2  AHB transfer type; htrans[1]=1 means NONSEQ/SEQ
read_select  input  2  register index: 0 payload_0, 1 payload_1, 2 data_size, 3 invalid
payload_0  input  8  register value from write path
payload_1  input  8  register value from write path
data_size  input  5  register value from write path
hrdata  output  8  read data, valid when hready_out=1 and hresp=0 in a read data phase
hready_out  output  1  slave HREADYOUT
hresp  output  1  0 OKAY, 1 ERROR

Behaviour:
- Reset (hreset=1, asynchronous, any state): state=IDLE, hrdata=0, hready_out=1, hresp=0, wait counter=0, captured select=0.
- Accept condition, evaluated at a rising edge: hsel_x && hready && !hwrite && htrans[1].
- Accept is evaluated only in IDLE, RESP and ERR2.
- Writes, IDLE/BUSY transfers and deselected cycles are never accepted. They get a zero-wait OKAY: next state IDLE, hready_out=1, hresp=0.
- On accept, read_select is captured.
- FSM states: IDLE, WAIT, RESP, ERR1, ERR2.
  - IDLE: hready_out=1, hresp=0, hrdata holds its last value.
  - On accept with select 3 -> ERR1.
  - On accept with select 0..2: if WAIT_STATES=0 -> RESP, else load counter with WAIT_STATES-1 and go to WAIT.
  - WAIT: hready_out=0, hresp=0. Counter decrements each cycle; when it is 0 -> RESP. New address phases are ignored (bus hready is low).
  - RESP: hready_out=1, hresp=0. hrdata is loaded on the edge entering RESP from the captured select.
    - payload_0 or payload_1 directly; data_size zero-extended to {3'b0, data_size}.
    - Register values are sampled at that edge, not at the address phase.
  - Leaving RESP: accept -> next transfer as from IDLE (back-to-back pipelining); otherwise -> IDLE.
  - ERR1: hready_out=0, hresp=1. Unconditionally -> ERR2.
  - ERR2: hready_out=1, hresp=1. Accept -> next transfer as from IDLE; otherwise -> IDLE.
- hrdata changes only on entry to RESP; it holds through IDLE, WAIT and the error states.
- Latency: address phase in cycle N -> completing data phase in cycle N+WAIT_STATES+1. With hready_out low in cycles N+1..N+WAIT_STATES.
- Error latency: ERROR completes in cycle N+2, regardless of WAIT_STATES.
- hsel_x dropping during WAIT or ERR1 does not abort; the data phase always completes.
- Reset asserted mid-WAIT or mid-ERR1 returns to IDLE immediately with reset outputs; no response is completed.

Test Plan:
- Reset: assert hreset asynchronously mid-cycle -> hrdata=0x00, hready_out=1, hresp=0 immediately.
- Single read, WAIT_STATES=1: payload_0=0xA5, read select 0 in cycle N -> N+1 hready_out=0; N+2 hready_out=1, hresp=0, hrdata=0xA5.
- Back-to-back, WAIT_STATES=0: payload_1=0x3C then data_size=5'h13, selects 1 then 2 in consecutive cycles -> hrdata 0x3C then 0x13 on consecutive cycles, hready_out held 1.
- Error: read select 3 -> cycle N+1 hready_out=0/hresp=1; N+2 hready_out=1/hresp=1; N+3 idle OKAY. hrdata unchanged.
- Filtering: hwrite=1, or htrans=2'b00, or hsel_x=0, or hready=0 with select 0 -> no state change, hready_out stays 1, hrdata unchanged.
- Reset mid-WAIT (WAIT_STATES=3): assert hreset in the second wait cycle -> IDLE, hready_out=1; the next accepted read completes normally after 3 waits.
